// File: rtl/gb_video_pkg.sv
// Shared video definitions for the LCD frame grabber.
//   H_ACT, V_ACT, FRAME_PIX : active frame geometry (160x144 = 23040 pixels)
//   grab_state_t            : capture controller states
//   pack555()               : RGB888 -> BGR555 re-pack (truncation, no rounding)
package gb_video_pkg;

  localparam int H_ACT     = 160;
  localparam int V_ACT     = 144;
  localparam int FRAME_PIX = H_ACT * V_ACT;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SYNC,
    CAPTURE,
    DONE
  } grab_state_t;

  // Inverse of the output expansion: keep the top 5 bits of each component.
  function automatic logic [14:0] pack555(input logic [7:0] r,
                                          input logic [7:0] g,
                                          input logic [7:0] b);
    return {b[7:3], g[7:3], r[7:3]};
  endfunction

endpackage

// File: rtl/grab_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port,
// single clock. A read of the address being written on the same edge
// returns the previous contents.
//   clk_vid : clock
//   we      : write enable
//   waddr   : write address
//   wdata   : write data
//   raddr   : read address
//   rdata   : registered read data
module grab_ram #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 15
) (
  input  logic              clk_vid,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // NOTE: the array has no reset; clearing it would prevent block-RAM
  // inference, and a partial frame must survive a reset anyway.
  always_ff @(posedge clk_vid) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/lcd_frame_grabber.sv
// Captures one active LCD frame into an internal buffer on request and
// exposes it through a pipelined host read port.
//   clk_vid, reset      : video clock, synchronous active-high reset
//   ce_pix, hbl, vbl    : pixel enable and blanking of the video stream
//   r, g, b             : 8-bit pixel components, valid when ce_pix is high
//   arm                 : pulse requesting a capture of the next frame
//   busy, done          : capture in progress / capture finished (sticky)
//   short_frame         : vbl rose before the frame was complete (sticky)
//   overflow            : a line carried too many active pixels (sticky)
//   pix_count           : pixels stored in the current/last capture
//   rd_req, rd_addr     : host read request and word address
//   rd_ack, rd_data     : read data valid (2 cycles later) and BGR555 word
module lcd_frame_grabber #(
  parameter int H_ACT  = gb_video_pkg::H_ACT,
  parameter int V_ACT  = gb_video_pkg::V_ACT,
  parameter int ADDR_W = 15
) (
  input  logic              clk_vid,
  input  logic              reset,
  input  logic              ce_pix,
  input  logic              hbl,
  input  logic              vbl,
  input  logic [7:0]        r,
  input  logic [7:0]        g,
  input  logic [7:0]        b,
  input  logic              arm,
  output logic              busy,
  output logic              done,
  output logic              short_frame,
  output logic              overflow,
  output logic [ADDR_W-1:0] pix_count,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [15:0]       rd_data
);

  import gb_video_pkg::*;

  localparam int COL_W = $clog2(H_ACT + 1);
  localparam int ROW_W = $clog2(V_ACT + 1);
  // The frame must fit strictly below 2^ADDR_W so these constants do not wrap.
  localparam logic [ADDR_W-1:0] FRAME_N  = ADDR_W'(H_ACT * V_ACT);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(H_ACT * V_ACT - 1);
  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(H_ACT);
  localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(V_ACT);

  grab_state_t state, state_n;

  logic              vbl_d;
  logic              frame_start, vbl_rise, active_px;
  logic [COL_W-1:0]  col, col_base;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en, start_cap, clr_flags, set_ovf, set_short, line_end;

  logic              rd_req_q, rd_in_range;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [14:0]       ram_q;

  assign frame_start = ce_pix & vbl_d & ~vbl;
  assign vbl_rise    = ce_pix & ~vbl_d & vbl;
  assign active_px   = ce_pix & ~hbl & ~vbl;

  // On the frame-start cycle the counters still hold the previous capture,
  // so the first pixel is addressed from zero directly.
  assign col_base = start_cap ? '0 : col;
  assign wr_addr  = start_cap ? '0 : pix_count;

  // NOTE: state is registered with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_vid) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // NOTE: every signal gets a default before the case statement; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_n   = state;
    wr_en     = 1'b0;
    start_cap = 1'b0;
    clr_flags = 1'b0;
    set_ovf   = 1'b0;
    set_short = 1'b0;
    line_end  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (arm) begin
          state_n   = WAIT_SYNC;
          clr_flags = 1'b1;
        end
      end
      WAIT_SYNC: begin
        busy = 1'b1;
        if (frame_start) begin
          state_n   = CAPTURE;
          start_cap = 1'b1;
          wr_en     = active_px;
        end
      end
      CAPTURE: begin
        busy     = 1'b1;
        line_end = ce_pix & hbl & (col != '0);
        if (vbl_rise) begin
          state_n   = DONE;
          set_short = 1'b1;
        end else if (active_px) begin
          if (col >= COL_MAX) begin
            set_ovf = 1'b1;
          end else if (row < ROW_MAX) begin
            wr_en = 1'b1;
            if (pix_count == LAST_PIX) state_n = DONE;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      vbl_d       <= 1'b0;
      col         <= '0;
      row         <= '0;
      pix_count   <= '0;
      short_frame <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (ce_pix) vbl_d <= vbl;
      if (clr_flags) begin
        pix_count   <= '0;
        short_frame <= 1'b0;
        overflow    <= 1'b0;
      end
      if (start_cap) begin
        col       <= '0;
        row       <= '0;
        pix_count <= '0;
      end
      if (wr_en) begin
        col       <= col_base + COL_W'(1);
        pix_count <= wr_addr + ADDR_W'(1);
      end
      if (line_end) begin
        col <= '0;
        if (row < ROW_MAX) row <= row + ROW_W'(1);
      end
      if (set_ovf)   overflow    <= 1'b1;
      if (set_short) short_frame <= 1'b1;
    end
  end

  // Read pipeline: stage 1 registers the request, stage 2 is the RAM output
  // register. Out-of-range addresses still acknowledge but return zero.
  always_ff @(posedge clk_vid) begin
    if (reset) begin
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      rd_ack      <= 1'b0;
      rd_in_range <= 1'b0;
    end else begin
      rd_req_q    <= rd_req;
      rd_addr_q   <= rd_addr;
      rd_ack      <= rd_req_q;
      rd_in_range <= rd_req_q & (rd_addr_q < FRAME_N);
    end
  end

  assign rd_data = rd_in_range ? {1'b0, ram_q} : 16'h0000;

  grab_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (15)
  ) u_ram (
    .clk_vid (clk_vid),
    .we      (wr_en & ~reset),
    .waddr   (wr_addr),
    .wdata   (pack555(r, g, b)),
    .raddr   (rd_addr_q),
    .rdata   (ram_q)
  );

endmodule
